// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate path: term opcodes,
// accumulator FSM states and the signed range limits of the default
// 64-bit accumulator.
package mac_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam int ACC_W_DEF = 64;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/sat_add_sub.sv
// Combinational signed add/subtract evaluated one bit wider than the
// accumulator, with overflow detection and optional clamping.
import mac_pkg::*;

module sat_add_sub #(
  parameter int ACC_W    = 64,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  input  logic                    sub,
  output logic signed [ACC_W-1:0] y,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  // The extra top bit carries the true sign of the result, so on overflow
  // it tells us which rail to clamp to; without clamping we keep the low
  // ACC_W bits, i.e. two's-complement wrap.
  function automatic logic signed [ACC_W-1:0] sat_clamp(
    input logic signed [ACC_W:0] v,
    input logic                  o
  );
    logic signed [ACC_W-1:0] r;
    r = v[ACC_W-1:0];
    if (o && SATURATE) begin
      r = v[ACC_W] ? MIN_V : MAX_V;
    end
    return r;
  endfunction

  logic signed [ACC_W:0] sum_ext;

  // Widened add/sub, overflow when the two top bits disagree, then clamp
  always_comb begin
    if (sub) begin
      sum_ext = $signed({a[ACC_W-1], a}) - $signed({b[ACC_W-1], b});
    end else begin
      sum_ext = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
    end
    ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    y   = sat_clamp(sum_ext, ovf);
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a block of signed multiplier products (add / subtract /
// load / nop per term) and presents the block result on a valid/ready
// output. Accumulate half of the MAC, ahead of ALU writeback.
import mac_pkg::*;

module product_accumulator #(
  parameter int PROD_W   = 64,
  parameter int ACC_W    = 64,
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_product,
  input  logic [1:0]               in_op,
  input  logic [LEN_W-1:0]         in_len,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_result,
  output logic                     out_sat
);

  state_e                  state, state_nxt;
  op_e                     op;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] addsub_y;
  logic                    addsub_ovf;
  logic                    term_ovf;
  logic [LEN_W-1:0]        count;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_eff;
  logic                    first_term;
  logic                    last_term;
  logic                    accept;
  logic                    sat_q;

  assign op       = op_e'(in_op);
  assign prod_ext = ACC_W'(in_product);
  assign accept   = in_valid && in_ready;

  sat_add_sub #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add_sub (
    .a   (acc_base),
    .b   (prod_ext),
    .sub (op == OP_SUB),
    .y   (addsub_y),
    .ovf (addsub_ovf)
  );

  // Term decode: the first term of a block starts from zero and latches
  // its length (zero length means a single-term block).
  always_comb begin
    first_term = (count == '0);
    acc_base   = first_term ? '0 : acc;
    len_eff    = len_q;
    if (first_term) begin
      len_eff = (in_len == '0) ? LEN_W'(1) : in_len;
    end
    last_term = (count == len_eff - LEN_W'(1));
    acc_nxt   = acc_base;
    term_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        acc_nxt  = addsub_y;
        term_ovf = addsub_ovf;
      end
      OP_LOAD: acc_nxt = prod_ext;
      default: acc_nxt = acc_base;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs; clear always returns to ACCUM
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_term) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_ACCUM;
      end
      default: state_nxt = ST_ACCUM;
    endcase
    if (clear) state_nxt = ST_ACCUM;
  end

  // ---- stage boundary: accepted term -> accumulator (1 cycle) ----
  // Accumulator, term counter, block length and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      sat_q <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      acc   <= acc_nxt;
      sat_q <= (first_term ? 1'b0 : sat_q) | term_ovf;
      count <= last_term ? '0 : count + LEN_W'(1);
      if (first_term) len_q <= len_eff;
    end else if (out_valid && out_ready) begin
      acc   <= '0;
      count <= '0;
      sat_q <= 1'b0;
    end
  end

  assign out_result = acc;
  assign out_sat    = sat_q;

endmodule
